// File: rtl/sprite_rom_arbiter_if.sv
// Bus between the sprite requesters, the shared sprite ROM and the arbiter.
// slave = arbiter side, master = requesters plus ROM side.
interface sprite_rom_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 3
);
  localparam int TAG_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  // req[i] is held high until gnt[i] is seen in the same cycle; a grant is a
  // completed transfer, and its data returns with rd_valid/rd_tag one cycle later.
  logic [NREQ-1:0]        req;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ-1:0]        gnt;
  logic [ADDR_W-1:0]      rom_address;
  logic [DATA_W-1:0]      rom_q;
  logic                   rd_valid;
  logic [TAG_W-1:0]       rd_tag;
  logic [DATA_W-1:0]      rd_data;

  modport slave (
    input  req, req_addr, rom_q,
    output gnt, rom_address, rd_valid, rd_tag, rd_data
  );

  modport master (
    output req, req_addr, rom_q,
    input  gnt, rom_address, rd_valid, rd_tag, rd_data
  );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite ROM among NREQ requesters.
// Optional macro SPRITE_ARB_PLAYER_PRIO_EN gives requester 0 absolute priority.
module sprite_rom_arbiter #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 3
) (
  input  logic                vga_clk,
  input  logic                reset_n,
  input  logic                frame_sync,
  sprite_rom_arbiter_if.slave bus
);
  localparam int TAG_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [TAG_W-1:0] LAST = TAG_W'(NREQ - 1);

  logic [TAG_W-1:0] ptr_q, ptr_d;
  logic [TAG_W-1:0] win_idx;
  logic [TAG_W-1:0] cand;
  logic [TAG_W-1:0] rd_tag_q;
  logic [NREQ-1:0]  rr_req;
  logic             win_found;
  logic             advance;
  logic             rd_valid_q;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    advance   = 1'b0;
    rr_req    = bus.req;
`ifdef SPRITE_ARB_PLAYER_PRIO_EN
    // Player sprite wins outright and leaves the rotation pointer alone.
    rr_req[0] = 1'b0;
    if (reset_n && bus.req[0]) begin
      win_found = 1'b1;
    end
`endif
    for (int k = 0; k < NREQ; k++) begin
      int c;
      c = int'(ptr_q) + k;
      if (c >= NREQ) c = c - NREQ;
      cand = TAG_W'(c);
      if (reset_n && !win_found && rr_req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
        advance   = 1'b1;
      end
    end

    ptr_d = ptr_q;
    if (advance) ptr_d = (win_idx == LAST) ? '0 : win_idx + 1'b1;
    if (frame_sync) ptr_d = '0;
  end

  always_comb begin
    bus.gnt         = '0;
    bus.rom_address = '0;
    if (win_found) begin
      bus.gnt[win_idx] = 1'b1;
      bus.rom_address  = bus.req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      ptr_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_tag_q   <= '0;
    end else begin
      ptr_q      <= ptr_d;
      rd_valid_q <= win_found;
      if (win_found) rd_tag_q <= win_idx;
    end
  end

  // A reset arriving while a read is in flight kills its return immediately.
  assign bus.rd_valid = rd_valid_q & reset_n;
  assign bus.rd_tag   = rd_tag_q;
  assign bus.rd_data  = bus.rd_valid ? bus.rom_q : '0;
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: directed vector table, then random traffic
// against a queue-free behavioural model of the round-robin rules.
module tb_sprite_rom_arbiter;
  localparam int NREQ   = 4;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 3;

  typedef struct {
    logic                   rst_n;
    logic                   fs;
    logic [NREQ-1:0]        req;
    logic [NREQ*ADDR_W-1:0] addrs;
    logic [NREQ-1:0]        g;
    logic [ADDR_W-1:0]      ra;
    logic                   v;
    logic [1:0]             t;
    logic [DATA_W-1:0]      d;
  } vec_t;

  logic vga_clk;
  logic reset_n;
  logic frame_sync;
  int   total;
  int   bad;

  sprite_rom_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sprite_rom_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .vga_clk    (vga_clk),
    .reset_n    (reset_n),
    .frame_sync (frame_sync),
    .bus        (bus)
  );

  // clock / reset
  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  // ROM model: data is the low three address bits, one edge late
  always_ff @(posedge vga_clk) bus.rom_q <= bus.rom_address[2:0];

  // reference model state
  int                m_ptr;
  bit                m_prev_found;
  logic [ADDR_W-1:0] m_prev_addr;
  int                m_tag;

  function automatic int model_pick(input logic [NREQ-1:0] r, input int ptr);
    logic [NREQ-1:0] rr;
    rr = r;
`ifdef SPRITE_ARB_PLAYER_PRIO_EN
    if (r[0]) return 0;
    rr[0] = 1'b0;
`endif
    for (int k = 0; k < NREQ; k++)
      if (rr[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock cycle: drive, check against the table row or the model, advance.
  task automatic do_cycle(input vec_t v, input bit from_model);
    vec_t e;
    int   win;
    bit   rr_grant;
    bus.req      = v.req;
    bus.req_addr = v.addrs;
    frame_sync   = v.fs;
    reset_n      = v.rst_n;

    win = v.rst_n ? model_pick(v.req, m_ptr) : -1;
    rr_grant = (win >= 0);
`ifdef SPRITE_ARB_PLAYER_PRIO_EN
    if (win == 0 && v.req[0]) rr_grant = 1'b0;
`endif
    e    = v;
    e.g  = (win >= 0) ? NREQ'(1 << win) : '0;
    e.ra = (win >= 0) ? v.addrs[win*ADDR_W +: ADDR_W] : '0;
    e.v  = m_prev_found && v.rst_n;
    e.d  = e.v ? m_prev_addr[2:0] : '0;
    e.t  = 2'(m_tag);
    if (!from_model) e = v;

    #4;
    chk("gnt",         32'(bus.gnt),         32'(e.g));
    chk("rom_address", 32'(bus.rom_address), 32'(e.ra));
    chk("rd_valid",    32'(bus.rd_valid),    32'(e.v));
    chk("rd_tag",      32'(bus.rd_tag),      32'(e.t));
    chk("rd_data",     32'(bus.rd_data),     32'(e.d));

    if (!v.rst_n) begin
      m_ptr        = 0;
      m_prev_found = 1'b0;
      m_tag        = 0;
    end else begin
      if (rr_grant) m_ptr = (win + 1) % NREQ;
      if (v.fs) m_ptr = 0;
      m_prev_found = (win >= 0);
      if (win >= 0) m_tag = win;
    end
    m_prev_addr = (win >= 0) ? v.addrs[win*ADDR_W +: ADDR_W] : '0;
    @(posedge vga_clk);
    #1;
  endtask

  localparam logic [NREQ*ADDR_W-1:0] DIR_ADDRS = {10'd40, 10'd30, 10'd20, 10'd10};

  function automatic vec_t mk(input bit rst_n, input bit fs, input logic [3:0] req,
                              input logic [3:0] g, input logic [9:0] ra, input bit v,
                              input int t, input int d);
    vec_t r;
    r.rst_n = rst_n; r.fs = fs; r.req = req; r.addrs = DIR_ADDRS;
    r.g = g; r.ra = ra; r.v = v; r.t = 2'(t); r.d = 3'(d);
    return r;
  endfunction

  vec_t tbl[$];
  vec_t rv;

  initial begin
    total = 0;
    bad   = 0;
    reset_n = 1'b0;
    frame_sync = 1'b0;
    bus.req = '0;
    bus.req_addr = '0;
    m_ptr = 0; m_prev_found = 1'b0; m_prev_addr = '0; m_tag = 0;
    @(posedge vga_clk);
    #1;

`ifndef SPRITE_ARB_PLAYER_PRIO_EN
    // reset ignores requests, then full rotation with returns
    tbl.push_back(mk(0, 0, 4'b1111, 4'b0000, 0,  0, 0, 0));
    tbl.push_back(mk(1, 0, 4'b1111, 4'b0001, 10, 0, 0, 0));
    tbl.push_back(mk(1, 0, 4'b1111, 4'b0010, 20, 1, 0, 2));
    tbl.push_back(mk(1, 0, 4'b1111, 4'b0100, 30, 1, 1, 4));
    tbl.push_back(mk(1, 0, 4'b1111, 4'b1000, 40, 1, 2, 6));
    tbl.push_back(mk(1, 0, 4'b1111, 4'b0001, 10, 1, 3, 0));
    // pointer wrap from 3 to 0, then pointer at 1
    tbl.push_back(mk(1, 0, 4'b0100, 4'b0100, 30, 1, 0, 2));
    tbl.push_back(mk(1, 0, 4'b0011, 4'b0001, 10, 1, 2, 6));
    tbl.push_back(mk(1, 0, 4'b0011, 4'b0010, 20, 1, 0, 2));
    // frame_sync restarts rotation at 0
    tbl.push_back(mk(1, 1, 4'b0100, 4'b0100, 30, 1, 1, 4));
    tbl.push_back(mk(1, 0, 4'b1111, 4'b0001, 10, 1, 2, 6));
    // idle: tag holds, data zero
    tbl.push_back(mk(1, 0, 4'b0000, 4'b0000, 0,  1, 0, 2));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1, 0, 4'b0000, 4'b0000, 0, 0, 0, 0));
    // grant then reset: return suppressed, pointer back to 0
    tbl.push_back(mk(1, 0, 4'b0010, 4'b0010, 20, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 4'b0000, 0,  0, 1, 0));
    tbl.push_back(mk(1, 0, 4'b1111, 4'b0001, 10, 0, 0, 0));
    tbl.push_back(mk(1, 0, 4'b0000, 4'b0000, 0,  1, 0, 2));
`else
    // player sprite always wins; others rotate without it
    tbl.push_back(mk(1, 0, 4'b1111, 4'b0001, 10, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1, 0, 4'b1111, 4'b0001, 10, 1, 0, 2));
    tbl.push_back(mk(1, 0, 4'b1110, 4'b0010, 20, 1, 0, 2));
    tbl.push_back(mk(1, 0, 4'b1110, 4'b0100, 30, 1, 1, 4));
    tbl.push_back(mk(1, 0, 4'b0000, 4'b0000, 0,  1, 2, 6));
`endif
    foreach (tbl[i]) do_cycle(tbl[i], 1'b0);

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      rv.rst_n = ($urandom_range(0, 31) != 0);
      rv.fs    = ($urandom_range(0, 15) == 0);
      rv.req   = NREQ'($urandom_range(0, 15));
      for (int i = 0; i < NREQ; i++)
        rv.addrs[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 1023));
      rv.g = '0; rv.ra = '0; rv.v = 1'b0; rv.t = '0; rv.d = '0;
      do_cycle(rv, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sprite_rom_arbiter.md
SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 Parameter NREQ, default 4; number of sprite requesters sharing one sprite ROM.
REQ-002 Parameter ADDR_W, default 10; ROM address width.
REQ-003 Parameter DATA_W, default 3; ROM data (palette index) width.
REQ-004 Port vga_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port reset_n  input  1  reset, synchronous, active-low.
REQ-006 Port frame_sync  input  1  one-cycle pulse at frame start; restarts arbitration order.
REQ-007 Port req  input  NREQ  per-requester read request, held high until granted.
REQ-008 Port req_addr  input  NREQ*ADDR_W  packed request addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
REQ-009 Port gnt  output  NREQ  one-hot grant, combinational, same cycle as winning req.
REQ-010 Port rom_address  output  ADDR_W  address to the shared synchronous ROM.
REQ-011 Port rom_q  input  DATA_W  ROM data, valid one vga_clk edge after rom_address.
REQ-012 Port rd_valid  output  1  registered; rd_data/rd_tag valid this cycle.
REQ-013 Port rd_tag  output  clog2(NREQ)  registered index of the requester owning rd_data.
REQ-014 Port rd_data  output  DATA_W  returned ROM data; rom_q when rd_valid=1, else 0.

Function
REQ-015 At most one gnt bit SHALL be high per cycle; gnt SHALL be 0 when req is 0 or reset_n=0.
REQ-016 Round-robin: search starts at pointer ptr, ascending modulo NREQ; first requester with req high wins.
REQ-017 After a grant to requester i, ptr SHALL become (i+1) mod NREQ (wrap NREQ-1 -> 0).
REQ-018 No request in a cycle: ptr unchanged, gnt=0, rom_address=0.
REQ-019 rom_address SHALL equal the granted requester's req_addr slice in the grant cycle (combinational).
REQ-020 Grant in cycle N -> rd_valid=1, rd_tag=i, rd_data=rom_q in cycle N+1; fixed latency 1, no stalls.
REQ-021 Cycle N with no grant -> rd_valid=0, rd_data=0, rd_tag holds its last value in N+1.
REQ-022 Back-to-back grants every cycle SHALL be supported; throughput one read per cycle.
REQ-023 Requester may drop req without grant; no grant or return SHALL be issued for it.
REQ-024 frame_sync high: arbitration that cycle uses current ptr; next ptr SHALL be 0, overriding REQ-017.
REQ-025 Requester granted in cycle N with req still high in N+1 is a new request, arbitrated normally.
REQ-026 No requester SHALL wait more than NREQ-1 grant cycles while holding req (round-robin mode).

Reset
REQ-027 reset_n=0 at a clock edge: ptr=0, rd_valid=0, rd_tag=0; rd_data=0 next cycle.
REQ-028 While reset_n=0, gnt=0 and rom_address=0; pending requests SHALL be ignored, not queued.
REQ-029 Reset asserted in cycle after a grant SHALL suppress that grant's return (rd_valid stays 0).

Configuration
REQ-030 Macro SPRITE_ARB_PLAYER_PRIO_EN defined: requester 0 (player sprite) SHALL win whenever req[0]=1; others round-robin among themselves per REQ-016/017, ptr unchanged by requester 0 grants.
REQ-031 Macro undefined: pure round-robin over all NREQ requesters per REQ-016 to REQ-026.

Verification
REQ-032 Reset, req=4'b1111 held, ROM model returns addr[2:0]; addrs 10,20,30,40 -> gnt 0001,0010,0100,1000,0001; rd_tag 0,1,2,3 one cycle later, rd_data 2,4,6,0.
REQ-033 ptr=3 via grant to 2, then req=4'b0011 -> gnt=0001 (wrap), next ptr=1.
REQ-034 req=4'b0100 with frame_sync=1 same cycle -> gnt=0100, rd_valid next cycle, subsequent req=4'b1111 -> gnt=0001.
REQ-035 Single grant in cycle N, reset_n=0 in cycle N+1 -> rd_valid=0, rd_data=0, ptr=0 after.
REQ-036 SPRITE_ARB_PLAYER_PRIO_EN defined, req=4'b1111 for 4 cycles -> gnt=0001 every cycle; req[0] drops -> gnt=0010 then 0100.
REQ-037 Idle req=0 for 5 cycles -> gnt=0, rom_address=0, rd_valid=0, rd_data=0 throughout.
